// File: rtl/ram_dual_port_arbiter.sv
// ram_dual_port_arbiter
// Shares one dual-read / single-write register RAM between two clients.
// Each cycle, one granted client issues two reads and an optional write.
// Read data returns one cycle later and is tagged to the issuing client.
// Addresses above MEM_SIZE are flagged. An offending write is dropped,
// and an offending read lane returns zero.
module ram_dual_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_SIZE   = 8
) (
    input  logic                         Clock,
    input  logic                         Reset_n,
    input  logic [1:0]                   iReq,
    input  logic [1:0]                   iLock,
    input  logic [1:0]                   iWe,
    input  logic [ADDR_WIDTH-1:0]        iRdAddr0_c0,
    input  logic [ADDR_WIDTH-1:0]        iRdAddr0_c1,
    input  logic [ADDR_WIDTH-1:0]        iRdAddr1_c0,
    input  logic [ADDR_WIDTH-1:0]        iRdAddr1_c1,
    input  logic [ADDR_WIDTH-1:0]        iWrAddr_c0,
    input  logic [ADDR_WIDTH-1:0]        iWrAddr_c1,
    input  logic signed [DATA_WIDTH-1:0] iWrData_c0,
    input  logic signed [DATA_WIDTH-1:0] iWrData_c1,
    output logic [1:0]                   oGrant,
    output logic [1:0]                   oValid,
    output logic signed [DATA_WIDTH-1:0] oRdData0,
    output logic signed [DATA_WIDTH-1:0] oRdData1,
    output logic [1:0]                   oAddrErr,
    output logic                         oRamWriteEnable,
    output logic [ADDR_WIDTH-1:0]        oRamReadAddress0,
    output logic [ADDR_WIDTH-1:0]        oRamReadAddress1,
    output logic [ADDR_WIDTH-1:0]        oRamWriteAddress,
    output logic signed [DATA_WIDTH-1:0] oRamDataIn,
    input  logic signed [DATA_WIDTH-1:0] iRamDataOut0,
    input  logic signed [DATA_WIDTH-1:0] iRamDataOut1
);

    localparam logic [ADDR_WIDTH-1:0] LP_ADDR_MAX = ADDR_WIDTH'(MEM_SIZE);

    typedef enum logic [1:0] {
        ST_RR    = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_ptr;          // round-robin pointer: client favoured on a tie
    logic   w_ptr_nxt;

    logic [1:0] w_grant;
    logic       w_any;
    logic       w_sel;      // index of the granted client (valid when w_any)
    logic       w_we;
    logic       w_lock;

    logic [ADDR_WIDTH-1:0]        w_rd_addr0;
    logic [ADDR_WIDTH-1:0]        w_rd_addr1;
    logic [ADDR_WIDTH-1:0]        w_wr_addr;
    logic signed [DATA_WIDTH-1:0] w_wr_data;

    logic w_err_rd0;
    logic w_err_rd1;
    logic w_err_wr;
    logic w_err;

    // Last issued RAM request, held on the RAM ports while idle
    logic [ADDR_WIDTH-1:0]        r_rd_addr0;
    logic [ADDR_WIDTH-1:0]        r_rd_addr1;
    logic [ADDR_WIDTH-1:0]        r_wr_addr;
    logic signed [DATA_WIDTH-1:0] r_wr_data;

    // Return tag and error flags for the request issued last cycle
    logic [1:0] r_valid;
    logic [1:0] r_addr_err;
    logic       r_lane_err0;
    logic       r_lane_err1;

    // State register: arbitration mode and round-robin pointer
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_RR;
            r_ptr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next-state logic: enter lock on a locked grant, leave lock when the owner releases
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_RR: begin
                if (w_any) begin
                    w_ptr_nxt = ~w_sel;
                    if (w_lock) begin
                        w_state_nxt = w_sel ? ST_LOCK1 : ST_LOCK0;
                    end
                end
            end
            ST_LOCK0: begin
                if (!iReq[0] || !iLock[0]) begin
                    w_state_nxt = ST_RR;
                    w_ptr_nxt   = 1'b1;
                end
            end
            ST_LOCK1: begin
                if (!iReq[1] || !iLock[1]) begin
                    w_state_nxt = ST_RR;
                    w_ptr_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_RR;
                w_ptr_nxt   = 1'b0;
            end
        endcase
    end

    // Output logic: combinational one-hot grant, forced low while in reset
    always_comb begin
        w_grant = '0;
        if (Reset_n) begin
            case (r_state)
                ST_RR: begin
                    if (iReq == 2'b11) begin
                        w_grant = r_ptr ? 2'b10 : 2'b01;
                    end else begin
                        w_grant = iReq;
                    end
                end
                ST_LOCK0: w_grant = {1'b0, iReq[0]};
                ST_LOCK1: w_grant = {iReq[1], 1'b0};
                default:  w_grant = '0;
            endcase
        end
    end

    // Request mux from the granted client and address range check
    always_comb begin
        w_any      = |w_grant;
        w_sel      = w_grant[1];
        w_we       = w_sel ? iWe[1]         : iWe[0];
        w_lock     = w_sel ? iLock[1]       : iLock[0];
        w_rd_addr0 = w_sel ? iRdAddr0_c1    : iRdAddr0_c0;
        w_rd_addr1 = w_sel ? iRdAddr1_c1    : iRdAddr1_c0;
        w_wr_addr  = w_sel ? iWrAddr_c1     : iWrAddr_c0;
        w_wr_data  = w_sel ? iWrData_c1     : iWrData_c0;
        w_err_rd0  = w_rd_addr0 > LP_ADDR_MAX;
        w_err_rd1  = w_rd_addr1 > LP_ADDR_MAX;
        w_err_wr   = w_we && (w_wr_addr > LP_ADDR_MAX);
        w_err      = w_err_rd0 || w_err_rd1 || w_err_wr;
    end

    // RAM port drive: live request on a grant, otherwise the held copy with no write
    always_comb begin
        oGrant           = w_grant;
        oRamWriteEnable  = w_any && w_we && !w_err_wr;
        oRamReadAddress0 = w_any ? w_rd_addr0 : r_rd_addr0;
        oRamReadAddress1 = w_any ? w_rd_addr1 : r_rd_addr1;
        oRamWriteAddress = w_any ? w_wr_addr  : r_wr_addr;
        oRamDataIn       = w_any ? w_wr_data  : r_wr_data;
    end

    // Hold the last issued addresses and data so the RAM ports stay stable while idle
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rd_addr0 <= '0;
            r_rd_addr1 <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else if (w_any) begin
            r_rd_addr0 <= w_rd_addr0;
            r_rd_addr1 <= w_rd_addr1;
            r_wr_addr  <= w_wr_addr;
            r_wr_data  <= w_wr_data;
        end
    end

    // Return tag: every grant, write or not, produces read data next cycle
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_valid     <= '0;
            r_addr_err  <= '0;
            r_lane_err0 <= 1'b0;
            r_lane_err1 <= 1'b0;
        end else begin
            r_valid     <= w_grant;
            r_addr_err  <= w_err ? w_grant : 2'b00;
            r_lane_err0 <= w_any && w_err_rd0;
            r_lane_err1 <= w_any && w_err_rd1;
        end
    end

    // Read return: RAM output passed through, zeroed when idle or on an offending lane
    always_comb begin
        oValid   = r_valid;
        oAddrErr = r_addr_err;
        oRdData0 = ((|r_valid) && !r_lane_err0) ? iRamDataOut0 : '0;
        oRdData1 = ((|r_valid) && !r_lane_err1) ? iRamDataOut1 : '0;
    end

endmodule
